// File: rtl/iq_pkg.sv
// Shared types and constants for the dual-issue instruction queue.
// Opcodes, the NOP encoding and the stored entry layout.
package iq_pkg;

  localparam int IQ_XLEN = 32;

  localparam logic [31:0] IQ_NOP = 32'h0000_0013;

  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [IQ_XLEN-1:0] instr;
    logic [IQ_XLEN-1:0] pc;
  } iq_entry_t;

endpackage

// File: rtl/iq_pair_check.sv
// Intra-pair RAW detector: blocks slot B when it reads slot A's rd.
// Only instantiated when IQ_PAIR_CHECK_EN is defined.
module iq_pair_check
  import iq_pkg::*;
(
  input  logic [IQ_XLEN-1:0] instr_a_i,
  input  logic [IQ_XLEN-1:0] instr_b_i,
  output logic               pair_ok_o
);

  logic [6:0] opc_a;
  logic [4:0] rd_a;
  logic [4:0] rs1_b;
  logic [4:0] rs2_b;
  logic       a_writes;
  logic       hazard;
  logic       unused_bits;

  assign opc_a = instr_a_i[6:0];
  assign rd_a  = instr_a_i[11:7];
  assign rs1_b = instr_b_i[19:15];
  assign rs2_b = instr_b_i[24:20];

  always_comb begin
    a_writes = 1'b1;
    unique case (1'b1)
      (opc_a == OPC_STORE):  a_writes = 1'b0;
      (opc_a == OPC_BRANCH): a_writes = 1'b0;
      default:               a_writes = 1'b1;
    endcase
  end

  assign hazard = a_writes && (rd_a != 5'd0) &&
                  ((rd_a == rs1_b) || (rd_a == rs2_b));

  assign pair_ok_o = !hazard;

  assign unused_bits = ^{instr_a_i[31:12],
                         instr_b_i[31:25],
                         instr_b_i[14:0]};

endmodule

// File: rtl/instr_queue.sv
// Circular instruction queue: 2-wide push from fetch, 2-wide issue.
// Define IQ_PAIR_CHECK_EN to hold back slot B on an intra-pair RAW.
module instr_queue
  import iq_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     fetch_valid_i,
  input  logic [DATA_WIDTH-1:0]    InstrA_i,
  input  logic [DATA_WIDTH-1:0]    InstrB_i,
  input  logic [DATA_WIDTH-1:0]    PC_i,
  output logic                     fetch_ready_o,
  input  logic                     dec_ready_i,
  output logic [DATA_WIDTH-1:0]    IssueA_o,
  output logic [DATA_WIDTH-1:0]    IssueB_o,
  output logic [DATA_WIDTH-1:0]    PCA_o,
  output logic [DATA_WIDTH-1:0]    PCB_o,
  output logic                     validA_o,
  output logic                     validB_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] head_p1;
  logic [PW-1:0] tail_p1;

  iq_entry_t mem_q [DEPTH];
  iq_entry_t ent_a;
  iq_entry_t ent_b;

  logic       push;
  logic       pair_ok;
  logic [1:0] pop_n;

  assign head_p1 = head_q + 1'b1;
  assign tail_p1 = tail_q + 1'b1;

  // Registered count only, so decode readiness never reaches fetch.
  assign fetch_ready_o = (count_q <= CW'(DEPTH - 2));
  assign push = fetch_valid_i && fetch_ready_o && !flush_i;

  assign ent_a = mem_q[head_q];
  assign ent_b = mem_q[head_p1];

`ifdef IQ_PAIR_CHECK_EN
  iq_pair_check u_pair_check (
    .instr_a_i (ent_a.instr),
    .instr_b_i (ent_b.instr),
    .pair_ok_o (pair_ok)
  );
`else
  assign pair_ok = 1'b1;
`endif

  assign validA_o = (count_q != '0);
  assign validB_o = (count_q >= CW'(2)) && pair_ok;

  assign IssueA_o = validA_o ? ent_a.instr : IQ_NOP;
  assign IssueB_o = validB_o ? ent_b.instr : IQ_NOP;
  assign PCA_o    = validA_o ? ent_a.pc : '0;
  assign PCB_o    = validB_o ? ent_b.pc : '0;
  assign count_o  = count_q;

  assign pop_n = dec_ready_i ?
                 ({1'b0, validA_o} + {1'b0, validB_o}) : 2'd0;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        tail_d = tail_q + PW'(2);
      end
      head_d  = head_q + PW'(pop_n);
      count_d = count_q + (push ? CW'(2) : CW'(0)) - CW'(pop_n);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage carries no reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[tail_q]  <= '{instr: InstrA_i, pc: PC_i};
      mem_q[tail_p1] <= '{instr: InstrB_i,
                          pc: PC_i + DATA_WIDTH'(4)};
    end
  end

endmodule

// File: tb/tb_instr_queue.sv
// Directed bench for instr_queue with an in-order issue scoreboard.
// Builds with or without IQ_PAIR_CHECK_EN.
module tb_instr_queue;
  import iq_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush_i = 1'b0;
  logic        fetch_valid_i = 1'b0;
  logic        dec_ready_i = 1'b0;
  logic [31:0] InstrA_i = '0;
  logic [31:0] InstrB_i = '0;
  logic [31:0] PC_i = '0;
  logic        fetch_ready_o;
  logic [31:0] IssueA_o, IssueB_o, PCA_o, PCB_o;
  logic        validA_o, validB_o;
  logic [3:0]  count_o;

  int total = 0;
  int bad = 0;
  iq_entry_t exp_q[$];

  instr_queue #(.DATA_WIDTH(32), .DEPTH(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush_i       (flush_i),
    .fetch_valid_i (fetch_valid_i),
    .InstrA_i      (InstrA_i),
    .InstrB_i      (InstrB_i),
    .PC_i          (PC_i),
    .fetch_ready_o (fetch_ready_o),
    .dec_ready_i   (dec_ready_i),
    .IssueA_o      (IssueA_o),
    .IssueB_o      (IssueB_o),
    .PCA_o         (PCA_o),
    .PCB_o         (PCB_o),
    .validA_o      (validA_o),
    .validB_o      (validB_o),
    .count_o       (count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic mon_slot(input string name,
                          input logic [31:0] instr,
                          input logic [31:0] pc);
    iq_entry_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s_unexpected actual=%h required=none",
               name, instr);
    end else begin
      e = exp_q.pop_front();
      chk({name, "_instr"}, instr, e.instr);
      chk({name, "_pc"}, pc, e.pc);
    end
  endtask

  // Monitor: every slot consumed by decode must match the next expected entry.
  always @(negedge clk) begin
    if (rst && !flush_i && dec_ready_i) begin
      if (validA_o) mon_slot("slotA", IssueA_o, PCA_o);
      if (validB_o) mon_slot("slotB", IssueB_o, PCB_o);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pair(input logic [31:0] a,
                            input logic [31:0] b,
                            input logic [31:0] pc,
                            input bit accept);
    fetch_valid_i = 1'b1;
    InstrA_i = a;
    InstrB_i = b;
    PC_i = pc;
    if (accept) begin
      exp_q.push_back('{instr: a, pc: pc});
      exp_q.push_back('{instr: b, pc: pc + 32'd4});
    end
  endtask

  function automatic logic [31:0] nop_k(input int k);
    return IQ_NOP | (32'(k) << 20);
  endfunction

  initial begin
    #3;
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_validA", 32'(validA_o), 32'd0);
    chk("rst_validB", 32'(validB_o), 32'd0);
    chk("rst_fetch_ready", 32'(fetch_ready_o), 32'd1);
    chk("rst_issueA", IssueA_o, IQ_NOP);
    chk("rst_pcA", PCA_o, 32'd0);
    #4 rst = 1'b1;
    tick();

    drive_pair(32'h00500093, 32'h00600113, 32'h0, 1'b1);
    tick();
    fetch_valid_i = 1'b0;
    chk("first_validA", 32'(validA_o), 32'd1);
    chk("first_validB", 32'(validB_o), 32'd1);
    chk("first_pcA", PCA_o, 32'h0);
    chk("first_pcB", PCB_o, 32'h4);
    chk("first_count", 32'(count_o), 32'd2);
    dec_ready_i = 1'b1;
    tick();
    dec_ready_i = 1'b0;
    chk("drain_count", 32'(count_o), 32'd0);

    for (int k = 0; k < 4; k++) begin
      drive_pair(nop_k(2 * k), nop_k(2 * k + 1),
                 32'h100 + 32'(8 * k), 1'b1);
      tick();
    end
    fetch_valid_i = 1'b0;
    chk("full_count", 32'(count_o), 32'd8);
    chk("full_fetch_ready", 32'(fetch_ready_o), 32'd0);
    drive_pair(32'h7ff00013, 32'h7fe00013, 32'h180, 1'b0);
    tick();
    fetch_valid_i = 1'b0;
    chk("drop_count", 32'(count_o), 32'd8);
    chk("drop_fetch_ready", 32'(fetch_ready_o), 32'd0);

    dec_ready_i = 1'b1;
    tick();
    chk("pop1_count", 32'(count_o), 32'd6);
    tick();
    chk("pop2_count", 32'(count_o), 32'd4);
    drive_pair(nop_k(20), nop_k(21), 32'h300, 1'b1);
    tick();
    chk("pushpop1_count", 32'(count_o), 32'd4);
    drive_pair(nop_k(22), nop_k(23), 32'h308, 1'b1);
    tick();
    chk("pushpop2_count", 32'(count_o), 32'd4);
    dec_ready_i = 1'b0;
    drive_pair(nop_k(24), nop_k(25), 32'h310, 1'b1);
    tick();
    fetch_valid_i = 1'b0;
    chk("six_count", 32'(count_o), 32'd6);

    flush_i = 1'b1;
    dec_ready_i = 1'b1;
    drive_pair(nop_k(26), nop_k(27), 32'h400, 1'b0);
    exp_q.delete();
    tick();
    flush_i = 1'b0;
    fetch_valid_i = 1'b0;
    dec_ready_i = 1'b0;
    chk("flush_count", 32'(count_o), 32'd0);
    chk("flush_validA", 32'(validA_o), 32'd0);
    chk("flush_validB", 32'(validB_o), 32'd0);
    chk("flush_issueA", IssueA_o, IQ_NOP);
    chk("flush_issueB", IssueB_o, IQ_NOP);
    chk("flush_pcA", PCA_o, 32'd0);

    drive_pair(32'h00100093, 32'h00108133, 32'h200, 1'b1);
    tick();
    fetch_valid_i = 1'b0;
    chk("raw_validA", 32'(validA_o), 32'd1);
`ifdef IQ_PAIR_CHECK_EN
    chk("raw_validB", 32'(validB_o), 32'd0);
`else
    chk("raw_validB", 32'(validB_o), 32'd1);
`endif
    dec_ready_i = 1'b1;
    tick();
`ifdef IQ_PAIR_CHECK_EN
    chk("raw_next_count", 32'(count_o), 32'd1);
    chk("raw_next_validA", 32'(validA_o), 32'd1);
    chk("raw_next_pcA", PCA_o, 32'h204);
    chk("raw_next_issueA", IssueA_o, 32'h00108133);
    chk("raw_next_validB", 32'(validB_o), 32'd0);
`else
    chk("raw_next_count", 32'(count_o), 32'd0);
    chk("raw_next_validA", 32'(validA_o), 32'd0);
`endif
    tick();
    chk("raw_drain_count", 32'(count_o), 32'd0);
    tick();
    chk("empty_pop_count", 32'(count_o), 32'd0);
    chk("empty_pop_validA", 32'(validA_o), 32'd0);
    chk("empty_fetch_ready", 32'(fetch_ready_o), 32'd1);
    dec_ready_i = 1'b0;

    drive_pair(32'h00a00013, 32'h00b00013, 32'h500, 1'b1);
    tick();
    drive_pair(32'h00c00013, 32'h00d00013, 32'h508, 1'b1);
    tick();
    chk("burst_count", 32'(count_o), 32'd4);
    drive_pair(32'h00e00013, 32'h00f00013, 32'h510, 1'b0);
    #1 rst = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_count", 32'(count_o), 32'd0);
    chk("arst_validA", 32'(validA_o), 32'd0);
    chk("arst_validB", 32'(validB_o), 32'd0);
    chk("arst_fetch_ready", 32'(fetch_ready_o), 32'd1);
    chk("arst_issueA", IssueA_o, IQ_NOP);
    chk("arst_issueB", IssueB_o, IQ_NOP);
    chk("arst_pcA", PCA_o, 32'd0);
    chk("arst_pcB", PCB_o, 32'd0);
    fetch_valid_i = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("post_rst_count", 32'(count_o), 32'd0);
    chk("scoreboard_left", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
